vertexinput_job_ctrl: RTL and testbench
=======================================

# vertexinput_job_ctrl

Sequencer for one vertex-input job, driven by the REG_DESC_0 register fields (config0 mode, config1 count, startpulse, status, interruptflag). On a start pulse it latches the job configuration, issues vertex-fetch requests to the fetch datapath with a valid/ready handshake, and tracks outstanding responses. It reports status back through the register adapter and raises read-clear interrupt flags on completion or error.

## Interface
Parameters:
- CNT_W, 25, vertex count/index width (matches config1 field)
- MAX_OUTSTANDING, 4, max requests in flight (power of two, ≥1)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_mode  in  2  from REG_DESC_0_config0_wo; 0=1, 1=2, 2=4 vertices per request, 3=reserved
- cfg_count  in  CNT_W  from REG_DESC_0_config1_rw; total vertices
- start_pulse  in  1  from REG_DESC_0_startpulse_pulse
- status  out  2  to REG_DESC_0_status_ro; 0=IDLE, 1=BUSY, 2=DONE, 3=ERROR
- irq_flag  out  2  to REG_DESC_0_interruptflag_rc_in; bit0=done, bit1=error
- irq_clr  in  2  from REG_DESC_0_interruptflag_rc_clr; per-bit clear
- req_valid  out  1  request to fetch datapath
- req_ready  in  1  datapath accepts request
- req_index  out  CNT_W  first vertex index of request
- req_len  out  3  vertices in request (1, 2 or 4)
- rsp_valid  in  1  one response per accepted request, in order
- rsp_err  in  1  qualified by rsp_valid; fetch failed

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: on start_pulse latch cfg_mode, cfg_count; set next_index=0, remaining=cfg_count.
  - mode 3: no requests; status=ERROR, irq_flag[1] set; stay IDLE.
  - count 0: no requests; status=DONE, irq_flag[0] set; stay IDLE.
  - otherwise go ISSUE, status=BUSY.
- ISSUE: req_valid=1 while outstanding < MAX_OUTSTANDING and remaining > 0 and no error seen. req_len = min(step, remaining); req_index = next_index. On req_valid&&req_ready: next_index += req_len, remaining -= req_len, outstanding++. When remaining hits 0 → DRAIN.
- DRAIN: no new requests; wait until outstanding = 0.
- rsp_valid: outstanding--. rsp_err latches err_seen; in ISSUE move to DRAIN immediately (a request already held valid is still completed if ready is high that same cycle).
- Job end (DRAIN, outstanding 0): → IDLE; status=ERROR and irq_flag[1] set if err_seen, else status=DONE and irq_flag[0] set. status holds until next accepted start.
- start_pulse while ISSUE/DRAIN: ignored, no state change.
- rsp_valid with outstanding 0: ignored, counter does not underflow.
- Accept and response same cycle: outstanding unchanged.
- irq_flag bits sticky until corresponding irq_clr bit; set and clear same cycle on same bit: set wins.
- Arithmetic: remaining/next_index are CNT_W bits, no wrap (next_index ≤ cfg_count); outstanding is clog2(MAX_OUTSTANDING)+1 bits.

## Timing
- Reset: status=0, irq_flag=0, req_valid=0, req_index=0, req_len=0, state IDLE, all counters 0. Reset mid-job aborts immediately, no irq; late responses after reset are ignored.
- start_pulse sampled at edge T → status=BUSY and first req_valid visible after edge T+1 (1-cycle latency).
- req_valid, req_index, req_len stable while req_valid && !req_ready; back-to-back accepts at 1 per cycle when ready held high.
- Last response at edge T → status and irq_flag updated after edge T+1; controller accepts a new start_pulse from T+1.
- Mode-3 / count-0 start at T → ERROR/DONE and irq after T+1.
- irq_clr at edge T → flag bit low after T.

## Structure
- Package vertexinput_job_ctrl_pkg: state enum (IDLE, ISSUE, DRAIN), status codes (ST_IDLE, ST_BUSY, ST_DONE, ST_ERROR), irq bit indices, function mode→step (0→1, 1→2, 2→4, 3→0 = invalid).
- One natural sub-module: vertexinput_irq_flags (per-bit sticky set/clear, set-wins); FSM and counters stay in the top.

## Test plan
- mode 0, count 3, ready always 1, response 2 cycles after accept → requests (0,1),(1,1),(2,1); status DONE, irq_flag=01; irq_clr=01 → irq_flag=00.
- mode 2, count 10 → requests (0,4),(4,4),(8,2); DONE after 3rd response.
- mode 0, count 8, MAX_OUTSTANDING=4, withhold responses → exactly 4 accepts then req_valid=0 until a response returns.
- mode 1, count 8, rsp_err on first response → no further requests after drain; status ERROR, irq_flag=10.
- mode 3 start → no req_valid, ERROR/irq_flag[1] after 1 cycle; count 0 start → DONE/irq_flag[0] after 1 cycle.
- start_pulse mid-job ignored; irq_clr same cycle as done-set keeps bit 1; rst mid-job → all outputs 0 next cycle.

Source files
------------

// File: rtl/vertexinput_job_ctrl_pkg.sv
// Shared types and helpers for the vertex-input job sequencer.
package vertexinput_job_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } status_e;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_ERR  = 1;

  // Vertices per request for a config0 mode; 0 marks the reserved encoding.
  function automatic logic [2:0] mode_step(input logic [1:0] mode);
    case (mode)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vertexinput_irq_flags.sv
// Sticky interrupt flags: set pulses accumulate until the matching clear bit; set wins.
// One-cycle latency for both set and clear; no backpressure.
module vertexinput_irq_flags #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] set,
  input  logic [W-1:0] clr,
  output logic [W-1:0] flag
);

  logic [W-1:0] flag_q, flag_d;

  always_comb begin
    flag_d = (flag_q & ~clr) | set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= '0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/vertexinput_job_ctrl.sv
// Vertex-input job sequencer: start pulse -> request stream (valid/ready) -> drain -> status/irq.
// Outputs registered, one cycle after the causing edge; requests hold while ready is low.
module vertexinput_job_ctrl
  import vertexinput_job_ctrl_pkg::*;
#(
  parameter int CNT_W           = 25,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start_pulse,
  output logic [1:0]       status,
  output logic [1:0]       irq_flag,
  input  logic [1:0]       irq_clr,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [CNT_W-1:0] req_index,
  output logic [2:0]       req_len,
  input  logic             rsp_valid,
  input  logic             rsp_err
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] next_index_q, next_index_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [OW-1:0]    outstanding_q, outstanding_d;
  logic             err_q, err_d;
  logic [1:0]       fin_q, fin_d;
  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] req_index_q, req_index_d;
  logic [2:0]       req_len_q, req_len_d;

  logic             accept;
  logic             rsp_take;
  logic [CNT_W-1:0] acc_len;
  logic [2:0]       step;
  logic [1:0]       irq_set;

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    mode_d        = mode_q;
    fin_d         = '0;
    irq_set       = '0;

    accept        = req_valid_q && req_ready;
    // A response with nothing in flight is stale (e.g. from before a reset).
    rsp_take      = rsp_valid && (outstanding_q != '0);
    acc_len       = accept ? CNT_W'(req_len_q) : '0;
    next_index_d  = next_index_q + acc_len;
    remaining_d   = remaining_q - acc_len;
    outstanding_d = outstanding_q + OW'(accept) - OW'(rsp_take);
    err_d         = err_q | (rsp_take & rsp_err);

    case (state_q)
      IDLE: begin
        // Degenerate starts finish one cycle later without leaving IDLE.
        if (fin_q != '0) begin
          status_d = fin_q[IRQ_ERR] ? ST_ERROR : ST_DONE;
          irq_set  = fin_q;
        end
        if (start_pulse) begin
          mode_d       = cfg_mode;
          next_index_d = '0;
          remaining_d  = cfg_count;
          err_d        = 1'b0;
          if (mode_step(cfg_mode) == 3'd0) begin
            fin_d[IRQ_ERR] = 1'b1;
          end else if (cfg_count == '0) begin
            fin_d[IRQ_DONE] = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        status_d = ST_BUSY;
        if (remaining_d == '0 || err_d) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          state_d           = IDLE;
          status_d          = err_q ? ST_ERROR : ST_DONE;
          irq_set[IRQ_ERR]  = err_q;
          irq_set[IRQ_DONE] = !err_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    step        = mode_step(mode_d);
    req_valid_d = (state_q == ISSUE) && (state_d == ISSUE) &&
                  (outstanding_d < OW'(MAX_OUTSTANDING));
    req_index_d = '0;
    req_len_d   = '0;
    if (req_valid_d) begin
      req_index_d = next_index_d;
      req_len_d   = (remaining_d < CNT_W'(step)) ? remaining_d[2:0] : step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      status_q      <= ST_IDLE;
      mode_q        <= '0;
      next_index_q  <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      fin_q         <= '0;
      req_valid_q   <= 1'b0;
      req_index_q   <= '0;
      req_len_q     <= '0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      mode_q        <= mode_d;
      next_index_q  <= next_index_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      fin_q         <= fin_d;
      req_valid_q   <= req_valid_d;
      req_index_q   <= req_index_d;
      req_len_q     <= req_len_d;
    end
  end

  vertexinput_irq_flags #(
    .W(2)
  ) u_irq_flags (
    .clk  (clk),
    .rst  (rst),
    .set  (irq_set),
    .clr  (irq_clr),
    .flag (irq_flag)
  );

  assign status    = status_q;
  assign req_valid = req_valid_q;
  assign req_index = req_index_q;
  assign req_len   = req_len_q;

endmodule

// File: tb/tb_vertexinput_job_ctrl.sv
// Randomized bench for vertexinput_job_ctrl against a transaction-level job model.
module tb_vertexinput_job_ctrl;
  import vertexinput_job_ctrl_pkg::*;

  localparam int CNT_W = 25;
  localparam int MAXO  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_count;
  logic             start_pulse;
  logic [1:0]       status;
  logic [1:0]       irq_flag;
  logic [1:0]       irq_clr;
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_index;
  logic [2:0]       req_len;
  logic             rsp_valid;
  logic             rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vertexinput_job_ctrl #(
    .CNT_W(CNT_W),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_mode    (cfg_mode),
    .cfg_count   (cfg_count),
    .start_pulse (start_pulse),
    .status      (status),
    .irq_flag    (irq_flag),
    .irq_clr     (irq_clr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_len     (req_len),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int step_of(input int mode);
    case (mode)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 0;
    endcase
  endfunction

  // Full job run: the model is the list of (index,len) chunks a job must produce.
  task automatic run_job(input int mode, input int count, input int ready_pct,
                         input int rsp_pct, input int err_at, input int hold,
                         input bit mid_start, input bit clr_during);
    int exp_idx[$];
    int exp_len[$];
    int step, acc_n, rsp_n, inflight, cyc, err_edge, last_rsp;
    int acc_after_err, extra_req, exp_irq, total_req;
    bit prev_acc, prev_rsp, prev_err, prev_stall, done;
    logic [2:0] old_status;
    logic [CNT_W+3:0] prev_out;

    step = step_of(mode);
    for (int i = 0; i < count; i += step) begin
      exp_idx.push_back(i);
      exp_len.push_back((count - i < step) ? count - i : step);
    end
    total_req = exp_idx.size();
    acc_n = 0; rsp_n = 0; inflight = 0; cyc = 0; err_edge = -1; last_rsp = -1;
    acc_after_err = 0; extra_req = 0;
    prev_acc = 0; prev_rsp = 0; prev_err = 0; prev_stall = 0; done = 0;
    prev_out = '0;

    old_status  = {1'b0, status};
    cfg_mode    = mode[1:0];
    cfg_count   = CNT_W'(count);
    start_pulse = 1'b1;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    irq_clr     = clr_during ? 2'b01 : 2'b00;
    tick();
    start_pulse = 1'b0;
    check("start_edge_status", {1'b0, status}, old_status);
    check("start_edge_vld", req_valid, 0);

    while (!done && cyc < 2000) begin
      tick();
      cyc++;
      if (prev_acc) begin
        if (err_edge >= 0) acc_after_err++;
        if (exp_idx.size() == 0) begin
          extra_req++;
        end else begin
          check("req_index", prev_out[CNT_W+2:3], exp_idx.pop_front());
          check("req_len", prev_out[2:0], exp_len.pop_front());
        end
        acc_n++;
        inflight++;
      end
      if (prev_rsp) begin
        inflight--;
        rsp_n++;
        last_rsp = cyc;
        if (prev_err && err_edge < 0) err_edge = cyc;
      end
      if (prev_acc) check("outstanding_cap", inflight <= MAXO, 1);
      if (cyc == 1) begin
        check("busy_latency", status, ST_BUSY);
        check("first_vld", req_valid, 1);
        check("first_index", req_index, 0);
        check("first_len", req_len, (count < step) ? count : step);
      end
      if (prev_stall && err_edge < 0)
        check("hold_stable", {req_valid, req_index, req_len}, prev_out);
      if (hold > 0 && cyc == hold) begin
        check("cap_accepts", acc_n, (total_req < MAXO) ? total_req : MAXO);
        check("cap_vld", req_valid, 0);
      end
      if (cyc > 1 && status != ST_BUSY) begin
        done = 1;
        exp_irq = (err_edge >= 0) ? 2 : 1;
        check("end_latency", cyc - last_rsp, 1);
        check("end_inflight", inflight, 0);
        check("end_status", status, (err_edge >= 0) ? ST_ERROR : ST_DONE);
        check("end_irq", irq_flag, exp_irq);
        check("end_vld", req_valid, 0);
        check("extra_req", extra_req, 0);
        if (err_edge >= 0) check("acc_after_err", acc_after_err, 0);
        else check("all_issued", acc_n, total_req);
      end else begin
        req_ready   = ($urandom_range(0, 99) < ready_pct);
        rsp_valid   = (inflight > 0) && (cyc >= hold) && ($urandom_range(0, 99) < rsp_pct);
        rsp_err     = rsp_valid && (rsp_n == err_at);
        start_pulse = mid_start && (cyc == 3);
        if (mid_start) begin
          cfg_mode  = 2'd1;
          cfg_count = CNT_W'(2);
        end
        prev_acc   = req_valid && req_ready;
        prev_rsp   = rsp_valid;
        prev_err   = rsp_err;
        prev_stall = req_valid && !req_ready;
        prev_out   = {req_valid, req_index, req_len};
      end
    end
    if (!done) check("job_timeout", cyc, 0);

    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    start_pulse = 1'b0;
    tick();
    exp_irq = (err_edge >= 0) ? 2 : 1;
    check("irq_sticky", irq_flag, clr_during ? (exp_irq & 2) : exp_irq);
    irq_clr = 2'b11;
    tick();
    check("irq_clear", irq_flag, 0);
    irq_clr = 2'b00;
  endtask

  task automatic quick_job(input int mode, input int count, input int exp_st, input int exp_irq);
    logic [1:0] old_status;
    old_status  = status;
    cfg_mode    = mode[1:0];
    cfg_count   = CNT_W'(count);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
    check("quick_edge_status", status, old_status);
    check("quick_edge_vld", req_valid, 0);
    tick();
    check("quick_status", status, exp_st);
    check("quick_irq", irq_flag, exp_irq);
    check("quick_vld", req_valid, 0);
    irq_clr = 2'b11;
    tick();
    check("quick_irq_clear", irq_flag, 0);
    irq_clr = 2'b00;
  endtask

  initial begin
    int m, c, nreq, e;
    rst = 1'b1; cfg_mode = '0; cfg_count = '0; start_pulse = 1'b0;
    irq_clr = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
    repeat (3) tick();
    check("rst_status", status, ST_IDLE);
    check("rst_irq", irq_flag, 0);
    check("rst_vld", req_valid, 0);
    check("rst_index", req_index, 0);
    check("rst_len", req_len, 0);
    rst = 1'b0;
    tick();

    run_job(0, 3, 100, 50, -1, 0, 0, 0);
    run_job(2, 10, 100, 60, -1, 0, 0, 0);
    run_job(0, 8, 100, 100, -1, 12, 0, 0);
    run_job(1, 8, 100, 100, 0, 0, 0, 0);
    quick_job(3, 5, ST_ERROR, 2);
    quick_job(0, 0, ST_DONE, 1);
    run_job(1, 20, 70, 50, -1, 0, 1, 1);

    for (int j = 0; j < 8; j++) begin
      m = $urandom_range(0, 2);
      c = $urandom_range(1, 40);
      nreq = (c + step_of(m) - 1) / step_of(m);
      e = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nreq - 1) : -1;
      run_job(m, c, $urandom_range(30, 100), $urandom_range(30, 100), e, 0, 0, 0);
    end

    // Reset in the middle of a job, then stale responses.
    cfg_mode = 2'd0; cfg_count = CNT_W'(8); start_pulse = 1'b1; req_ready = 1'b1;
    tick();
    start_pulse = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_ready = 1'b0;
    check("midrst_status", status, ST_IDLE);
    check("midrst_irq", irq_flag, 0);
    check("midrst_vld", req_valid, 0);
    check("midrst_index", req_index, 0);
    check("midrst_len", req_len, 0);
    rsp_valid = 1'b1; rsp_err = 1'b1;
    repeat (3) tick();
    rsp_valid = 1'b0; rsp_err = 1'b0;
    check("late_rsp_status", status, ST_IDLE);
    check("late_rsp_irq", irq_flag, 0);
    run_job(0, 2, 100, 100, -1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
